// File: rtl/fifo_stream_reader.sv
// Read-side master: pops fifo_dut words into a 2-entry skid and streams them out.
// Optional FIFO_STREAM_READER_STATS_EN adds stat_words / stat_stalls counters.
module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_empty,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             idle
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0]      stat_words,
  output logic [31:0]      stat_stalls
`endif
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;
  logic [CW-1:0]    beat_q, beat_d;
  logic             pop;
  logic [2:0]       level;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf0_q;
  assign m_last  = m_valid && (beat_q == LAST_BEAT);
  assign idle    = (state_q == S_IDLE);
  assign pop     = m_valid && m_ready;

  // Slots committed after this cycle: buffered plus in flight, minus the pop.
  assign level = 3'(occ_q) + 3'(inflight_q) - 3'(pop);

  assign fifo_rd_en = (state_q == S_RUN) && !fifo_empty && (level < 3'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_RUN;
      S_RUN:   if (!enable) state_d = S_DRAIN;
      S_DRAIN: if (!inflight_q && occ_q == 2'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    occ_d      = occ_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = fifo_rd_en;
    beat_d     = beat_q;
    case ({inflight_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = fifo_rdata;
        else               buf1_d = fifo_rdata;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_rdata;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_rdata;
        end
      end
      default: ;
    endcase
    if (pop) begin
      if (beat_q == LAST_BEAT) beat_d = '0;
      else                     beat_d = beat_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      beat_q     <= beat_d;
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] words_q, words_d;
  logic [31:0] stalls_q, stalls_d;

  always_comb begin
    words_d  = words_q;
    stalls_d = stalls_q;
    if (pop)                 words_d  = words_q + 32'd1;
    if (m_valid && !m_ready) stalls_d = stalls_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q  <= 32'd0;
      stalls_q <= 32'd0;
    end else begin
      words_q  <= words_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_words  = words_q;
  assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural fifo_dut read port.
// Define FIFO_STREAM_READER_STATS_EN to also exercise the statistics counters.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fifo_rd_en;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic       idle;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] stat_words;
  logic [31:0] stat_stalls;
`endif

  int checks   = 0;
  int failures = 0;
  int rd_cnt   = 0;

  logic [7:0] fq[$];
  logic [7:0] got_d[$];
  logic       got_l[$];

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(8), .BURST_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .idle       (idle)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_stalls(stat_stalls)
`endif
  );

  // fifo_dut read port: registered rdata, one cycle after rd_en.
  always @(posedge clk) begin
    logic [7:0] w;
    if (fifo_rd_en) begin
      rd_cnt++;
      if (fq.size() == 0) begin
        failures++;
        $display("FAIL rd_on_empty observed=1 expected=0");
      end else begin
        w = fq.pop_front();
        fifo_rdata <= w;
      end
    end
    fifo_empty <= (fq.size() == 0);
    if (m_valid && m_ready) begin
      got_d.push_back(m_data);
      got_l.push_back(m_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [7:0] v);
    fq.push_back(v);
    fifo_empty = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic seen;
    rst        = 1'b1;
    enable     = 1'b0;
    m_ready    = 1'b0;
    fifo_empty = 1'b1;
    fifo_rdata = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_idle", 32'(idle), 1);

    // Basic burst with m_ready held high.
    push_word(8'h11);
    push_word(8'h12);
    push_word(8'h13);
    push_word(8'h14);
    enable  = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("t2_rd_en_enable_cycle", 32'(fifo_rd_en), 0);
    tick();
    chk("t2_first_rd_en", 32'(fifo_rd_en), 1);
    chk("t2_not_idle", 32'(idle), 0);
    tick();
    chk("t2_no_valid_yet", 32'(m_valid), 0);
    tick();
    chk("t2_v0", 32'(m_valid), 1);
    chk("t2_d0", 32'(m_data), 32'h11);
    chk("t2_l0", 32'(m_last), 0);
    tick();
    chk("t2_d1", 32'(m_data), 32'h12);
    tick();
    chk("t2_d2", 32'(m_data), 32'h13);
    chk("t2_l2", 32'(m_last), 0);
    tick();
    chk("t2_d3", 32'(m_data), 32'h14);
    chk("t2_l3", 32'(m_last), 1);
    tick();
    chk("t2_v_end", 32'(m_valid), 0);

    // Backpressure: exactly two reads, then release.
    m_ready = 1'b0;
    rd_cnt  = 0;
    for (int i = 0; i < 6; i++) push_word(8'h21 + 8'(i));
    repeat (6) tick();
    chk("t3_rd_cnt", 32'(rd_cnt), 2);
    chk("t3_rd_en", 32'(fifo_rd_en), 0);
    chk("t3_valid", 32'(m_valid), 1);
    chk("t3_hold", 32'(m_data), 32'h21);
    got_d.delete();
    got_l.delete();
    m_ready = 1'b1;
    repeat (12) tick();
    chk("t3_count", 32'(got_d.size()), 6);
    for (int i = 0; i < 6 && i < got_d.size(); i++) begin
      chk($sformatf("t3_d%0d", i), 32'(got_d[i]), 32'h21 + i);
      chk($sformatf("t3_l%0d", i), 32'(got_l[i]), (i == 3) ? 1 : 0);
    end

    // Mid-stream reset with reads in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'h51 + 8'(i));
    repeat (3) tick();
    enable = 1'b0;
    rst    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    fq.delete();
    fifo_empty = 1'b1;
    #1;
    chk("t1_rd_en", 32'(fifo_rd_en), 0);
    chk("t1_valid", 32'(m_valid), 0);
    chk("t1_data", 32'(m_data), 0);
    chk("t1_last", 32'(m_last), 0);
    chk("t1_idle", 32'(idle), 1);

    // Burst marking with toggling m_ready; counter continues past 8.
    enable  = 1'b1;
    m_ready = 1'b1;
    got_d.delete();
    got_l.delete();
    for (int i = 0; i < 8; i++) push_word(8'h31 + 8'(i));
    for (int i = 0; i < 30; i++) begin
      tick();
      m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    repeat (4) tick();
    chk("t4_count8", 32'(got_d.size()), 8);
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      chk($sformatf("t4_d%0d", i), 32'(got_d[i]), 32'h31 + i);
      chk($sformatf("t4_l%0d", i), 32'(got_l[i]),
          (i == 3 || i == 7) ? 1 : 0);
    end
    push_word(8'h39);
    push_word(8'h3A);
    repeat (8) tick();
    chk("t4_count10", 32'(got_d.size()), 10);
    if (got_d.size() >= 10) begin
      chk("t4_d8", 32'(got_d[8]), 32'h39);
      chk("t4_l8", 32'(got_l[8]), 0);
      chk("t4_d9", 32'(got_d[9]), 32'h3A);
      chk("t4_l9", 32'(got_l[9]), 0);
    end

    // Disable after the second read with one word buffered.
    m_ready = 1'b0;
    got_d.delete();
    got_l.delete();
    for (int i = 0; i < 4; i++) push_word(8'h41 + 8'(i));
    tick();
    tick();
    chk("t5_buffered", 32'(m_data), 32'h41);
    enable = 1'b0;
    rd_cnt = 0;
    #1;
    chk("t5_rd_en_off", 32'(fifo_rd_en), 0);
    tick();
    chk("t5_drain_not_idle", 32'(idle), 0);
    chk("t5_head", 32'(m_data), 32'h41);
    m_ready = 1'b1;
    tick();
    chk("t5_second", 32'(m_data), 32'h42);
    chk("t5_second_v", 32'(m_valid), 1);
    tick();
    chk("t5_empty_v", 32'(m_valid), 0);
    chk("t5_empty_idle", 32'(idle), 0);
    tick();
    chk("t5_idle", 32'(idle), 1);
    chk("t5_no_reads", 32'(rd_cnt), 0);
    chk("t5_got2", 32'(got_d.size()), 2);
    enable = 1'b1;
    repeat (8) tick();
    chk("t5_got4", 32'(got_d.size()), 4);
    if (got_d.size() >= 4) begin
      chk("t5_g0", 32'(got_d[0]), 32'h41);
      chk("t5_g1", 32'(got_d[1]), 32'h42);
      chk("t5_g2", 32'(got_d[2]), 32'h43);
      chk("t5_g3", 32'(got_d[3]), 32'h44);
    end

`ifdef FIFO_STREAM_READER_STATS_EN
    // Statistics: 5 words, 3 stall cycles.
    enable = 1'b0;
    rst    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    fq.delete();
    fifo_empty = 1'b1;
    #1;
    chk("t6_words_rst", stat_words, 0);
    chk("t6_stalls_rst", stat_stalls, 0);
    enable  = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h61 + 8'(i));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = m_valid;
    end
    chk("t6_valid_seen", 32'(seen), 1);
    repeat (3) tick();
    m_ready = 1'b1;
    repeat (12) tick();
    chk("t6_words", stat_words, 5);
    chk("t6_stalls", stat_stalls, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
